// File: rtl/inst_fetch_ctrl_if.sv
// SRAM-like instruction fetch port between the fetch controller and the AXI bridge.
// The controller takes the master modport and the bridge takes the slave modport.
interface inst_fetch_ctrl_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_wr,
        output inst_sram_size,
        output inst_sram_wstrb,
        output inst_sram_addr,
        output inst_sram_wdata,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_wr,
        input  inst_sram_size,
        input  inst_sram_wstrb,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch stage controller: one outstanding fetch, a one-entry instruction buffer and redirect handling.
// Define FETCH_BYPASS_EN to forward returned data straight to decode when it can accept, skipping HOLD.
module inst_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h1c000000
) (
    input  logic                      clk,
    input  logic                      reset,
    inst_fetch_ctrl_if.master         sram,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      ds_allowin,
    output logic                      fs_to_ds_valid,
    output logic [31:0]               fs_pc,
    output logic [31:0]               fs_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_next;
    logic        discard;
    logic        discard_next;
    logic [31:0] ibuf_inst;
    logic [31:0] ibuf_inst_next;
    logic [31:0] ibuf_pc;
    logic [31:0] ibuf_pc_next;
    logic        req_int;
    logic        valid_int;

    assign sram.inst_sram_wr    = 1'b0;
    assign sram.inst_sram_size  = 2'b10;
    assign sram.inst_sram_wstrb = 4'b0000;
    assign sram.inst_sram_wdata = 32'h0;
    // fetch_pc only changes outside REQ, so the address stays put until the handshake completes
    assign sram.inst_sram_addr  = fetch_pc;
    assign sram.inst_sram_req   = req_int & ~reset;
    assign fs_to_ds_valid       = valid_int & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            fetch_pc  <= PC_RESET;
            pend_pc   <= 32'h0;
            discard   <= 1'b0;
            ibuf_inst <= 32'h0;
            ibuf_pc   <= PC_RESET;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            pend_pc   <= pend_pc_next;
            discard   <= discard_next;
            ibuf_inst <= ibuf_inst_next;
            ibuf_pc   <= ibuf_pc_next;
        end
    end

    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        pend_pc_next   = pend_pc;
        discard_next   = discard;
        ibuf_inst_next = ibuf_inst;
        ibuf_pc_next   = ibuf_pc;
        req_int        = 1'b0;
        valid_int      = 1'b0;
        fs_pc          = ibuf_pc;
        fs_inst        = ibuf_inst;

        case (state)
            S_REQ: begin
                req_int = 1'b1;
                if (redirect_valid) begin
                    pend_pc_next = redirect_pc;
                    discard_next = 1'b1;
                end
                if (sram.inst_sram_addr_ok) begin
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (sram.inst_sram_data_ok) begin
                    if (redirect_valid) begin
                        fetch_pc_next = redirect_pc;
                        discard_next  = 1'b0;
                        state_next    = S_REQ;
                    end else if (discard) begin
                        fetch_pc_next = pend_pc;
                        discard_next  = 1'b0;
                        state_next    = S_REQ;
                    end else begin
`ifdef FETCH_BYPASS_EN
                        if (ds_allowin) begin
                            valid_int     = 1'b1;
                            fs_inst       = sram.inst_sram_rdata;
                            fs_pc         = fetch_pc;
                            fetch_pc_next = fetch_pc + 32'd4;
                            state_next    = S_REQ;
                        end else begin
                            ibuf_inst_next = sram.inst_sram_rdata;
                            ibuf_pc_next   = fetch_pc;
                            state_next     = S_HOLD;
                        end
`else
                        ibuf_inst_next = sram.inst_sram_rdata;
                        ibuf_pc_next   = fetch_pc;
                        state_next     = S_HOLD;
`endif
                    end
                end else if (redirect_valid) begin
                    pend_pc_next = redirect_pc;
                    discard_next = 1'b1;
                end
            end

            S_HOLD: begin
                // A redirect kills the buffered instruction even if decode is ready for it
                if (redirect_valid) begin
                    ibuf_inst_next = 32'h0;
                    fetch_pc_next  = redirect_pc;
                    state_next     = S_REQ;
                end else begin
                    valid_int = 1'b1;
                    if (ds_allowin) begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        state_next    = S_REQ;
                    end
                end
            end

            default: begin
                state_next = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed testbench for inst_fetch_ctrl (default build, bypass disabled).
module tb_inst_fetch_ctrl;

    localparam logic [31:0] PC_RESET = 32'h1c000000;

    typedef struct {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        allowin;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    int errors;
    int checks;
    vec_t vecs[$];

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl #(.PC_RESET(PC_RESET)) dut (
        .clk            (clk),
        .reset          (reset),
        .sram           (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ds_allowin     (ds_allowin),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic aok, input logic dok, input logic [31:0] rd,
                               input logic rv, input logic [31:0] rpc, input logic al);
        bus.inst_sram_addr_ok = aok;
        bus.inst_sram_data_ok = dok;
        bus.inst_sram_rdata   = rd;
        redirect_valid        = rv;
        redirect_pc           = rpc;
        ds_allowin            = al;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveInputs(v.addr_ok, v.data_ok, v.rdata, v.redirect, v.redirect_pc, v.allowin);
        #1;
    endtask

    task automatic addVec(input logic aok, input logic dok, input logic [31:0] rd,
                          input logic rv, input logic [31:0] rpc, input logic al,
                          input logic ereq, input logic [31:0] eaddr,
                          input logic evalid, input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v.addr_ok = aok;   v.data_ok = dok;       v.rdata = rd;
        v.redirect = rv;   v.redirect_pc = rpc;   v.allowin = al;
        v.exp_req = ereq;  v.exp_addr = eaddr;
        v.exp_valid = evalid; v.exp_pc = epc;     v.exp_inst = einst;
        vecs.push_back(v);
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        checkOutput($sformatf("row%0d_req", idx), {31'h0, bus.inst_sram_req}, {31'h0, v.exp_req});
        if (v.exp_req)
            checkOutput($sformatf("row%0d_addr", idx), bus.inst_sram_addr, v.exp_addr);
        checkOutput($sformatf("row%0d_valid", idx), {31'h0, fs_to_ds_valid}, {31'h0, v.exp_valid});
        if (v.exp_valid) begin
            checkOutput($sformatf("row%0d_pc", idx), fs_pc, v.exp_pc);
            checkOutput($sformatf("row%0d_inst", idx), fs_inst, v.exp_inst);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        //      aok dok rdata         rv  rpc           al   req addr          vld pc            inst
        for (int i = 0; i < 5; i++)
            addVec(0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h1c000000,  0, 32'h0,        32'h0);
        addVec(1, 0, 32'h0,            0, 32'h0,        0,   1, 32'h1c000000,  0, 32'h0,        32'h0);
        addVec(0, 1, 32'h02800401,     0, 32'h0,        0,   0, 32'h0,         0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,            0, 32'h0,        1,   0, 32'h0,         1, 32'h1c000000, 32'h02800401);
        addVec(1, 0, 32'h0,            0, 32'h0,        0,   1, 32'h1c000004,  0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,            1, 32'h1c000100, 0,   0, 32'h0,         0, 32'h0,        32'h0);
        addVec(0, 1, 32'hdeadbeef,     0, 32'h0,        1,   0, 32'h0,         0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,            0, 32'h0,        1,   1, 32'h1c000100,  0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,            1, 32'h1c000200, 0,   1, 32'h1c000100,  0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,            0, 32'h0,        0,   1, 32'h1c000100,  0, 32'h0,        32'h0);
        addVec(1, 0, 32'h0,            0, 32'h0,        0,   1, 32'h1c000100,  0, 32'h0,        32'h0);
        addVec(0, 1, 32'h11111111,     0, 32'h0,        1,   0, 32'h0,         0, 32'h0,        32'h0);
        addVec(1, 0, 32'h0,            0, 32'h0,        0,   1, 32'h1c000200,  0, 32'h0,        32'h0);
        addVec(0, 1, 32'h22222222,     0, 32'h0,        0,   0, 32'h0,         0, 32'h0,        32'h0);
        for (int i = 0; i < 4; i++)
            addVec(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h0,         1, 32'h1c000200, 32'h22222222);
        addVec(0, 0, 32'h0,            1, 32'h1c000300, 1,   0, 32'h0,         0, 32'h0,        32'h0);
        addVec(1, 0, 32'h0,            0, 32'h0,        0,   1, 32'h1c000300,  0, 32'h0,        32'h0);
        addVec(0, 1, 32'h33333333,     0, 32'h0,        0,   0, 32'h0,         0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,            1, 32'hfffffffc, 0,   0, 32'h0,         0, 32'h0,        32'h0);
        addVec(1, 0, 32'h0,            0, 32'h0,        0,   1, 32'hfffffffc,  0, 32'h0,        32'h0);
        addVec(0, 1, 32'h44444444,     0, 32'h0,        0,   0, 32'h0,         0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,            0, 32'h0,        1,   0, 32'h0,         1, 32'hfffffffc, 32'h44444444);
        addVec(0, 1, 32'h55555555,     0, 32'h0,        0,   1, 32'h00000000,  0, 32'h0,        32'h0);
        addVec(0, 0, 32'h0,            0, 32'h0,        0,   1, 32'h00000000,  0, 32'h0,        32'h0);

        #2;
        checkOutput("rst_req",   {31'h0, bus.inst_sram_req}, 32'h0);
        checkOutput("rst_valid", {31'h0, fs_to_ds_valid},   32'h0);
        checkOutput("rst_pc",    fs_pc,   PC_RESET);
        checkOutput("rst_inst",  fs_inst, 32'h0);
        checkOutput("tie_wr",    {31'h0, bus.inst_sram_wr}, 32'h0);
        checkOutput("tie_size",  {30'h0, bus.inst_sram_size}, 32'h2);
        checkOutput("tie_wstrb", {28'h0, bus.inst_sram_wstrb}, 32'h0);
        checkOutput("tie_wdata", bus.inst_sram_wdata, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVec(i, vecs[i]);
        end

        // Reset while a discarded fetch is outstanding, then a clean fetch must deliver
        @(negedge clk);
        driveInputs(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("mr_req_a", {31'h0, bus.inst_sram_req}, 32'h1);
        @(negedge clk);
        driveInputs(1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000500, 1'b0);
        #1;
        checkOutput("mr_req_wait", {31'h0, bus.inst_sram_req}, 32'h0);
        @(negedge clk);
        driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("mr_req_rst",   {31'h0, bus.inst_sram_req}, 32'h0);
        checkOutput("mr_valid_rst", {31'h0, fs_to_ds_valid},   32'h0);
        checkOutput("mr_pc_rst",    fs_pc,   PC_RESET);
        checkOutput("mr_inst_rst",  fs_inst, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("mr_req_rel",  {31'h0, bus.inst_sram_req}, 32'h1);
        checkOutput("mr_addr_rel", bus.inst_sram_addr, PC_RESET);
        @(negedge clk);
        driveInputs(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("mr_addr_ok", bus.inst_sram_addr, PC_RESET);
        @(negedge clk);
        driveInputs(1'b0, 1'b1, 32'h66666666, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("mr_valid_data", {31'h0, fs_to_ds_valid}, 32'h0);
        @(negedge clk);
        driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("mr_valid_hold", {31'h0, fs_to_ds_valid}, 32'h1);
        checkOutput("mr_pc_hold",    fs_pc,   PC_RESET);
        checkOutput("mr_inst_hold",  fs_inst, 32'h66666666);
        @(negedge clk);
        driveInputs(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("mr_next_addr", bus.inst_sram_addr, 32'h1c000004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
